// File: rtl/fetch_issue_queue_if.sv
`default_nettype none
// =============================================================================
// Module : fetch_issue_queue_if
// Desc   : Memory fetch port, issue handshake and status of the front end.
// Rev    : 1.0  initial release
// =============================================================================
interface fetch_issue_queue_if;
  logic [31:0] prog_len;
  logic [31:0] pc;
  logic [31:0] instr_in;
  logic [3:0]  iss_op;
  logic [3:0]  iss_rd;
  logic [3:0]  iss_rs1;
  logic [3:0]  iss_rs2;
  logic        add_valid;
  logic        add_ready;
  logic        mul_valid;
  logic        mul_ready;
  logic        illegal;
  logic        done;

  // Front-end view: drives the fetch address and the issue offer.
  modport master (
    input  prog_len, instr_in, add_ready, mul_ready,
    output pc, iss_op, iss_rd, iss_rs1, iss_rs2,
    output add_valid, mul_valid, illegal, done
  );

  // Memory / reservation-station view.
  modport slave (
    output prog_len, instr_in, add_ready, mul_ready,
    input  pc, iss_op, iss_rd, iss_rs1, iss_rs2,
    input  add_valid, mul_valid, illegal, done
  );
endinterface
`default_nettype wire

// File: rtl/fetch_issue_queue.sv
`default_nettype none
// =============================================================================
// Module : fetch_issue_queue
// Desc   : PC fetch into an in-order queue; head decoded and issued to add/mul RS.
// Rev    : 1.0  initial release
// =============================================================================
module fetch_issue_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                clk1,
  input  logic                rst_n,
  fetch_issue_queue_if.master bus
);
  localparam logic [PTR_W:0] c_DEPTH = (PTR_W+1)'(DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             inflight_q, inflight_d;
  logic             illegal_q, illegal_d;
  logic [15:0]      mem_q [DEPTH];

  logic             w_empty;
  logic             w_fetch_en;
  logic             w_push;
  logic             w_pop;
  logic             w_add_cls;
  logic             w_mul_cls;
  logic             w_illegal_head;
  logic [15:0]      w_head;
  logic [PTR_W:0]   w_occupancy;
  logic             unused_hi;

  assign unused_hi = ^bus.instr_in[31:16];

  assign w_head         = mem_q[rd_ptr_q];
  assign w_empty        = (count_q == '0);
  assign w_add_cls      = (w_head[15:13] == 3'b000);
  assign w_mul_cls      = (w_head[15:13] == 3'b001);
  assign w_illegal_head = !w_empty && !w_add_cls && !w_mul_cls;

  // The in-flight word already owns a slot, so it counts toward occupancy.
  assign w_occupancy = count_q + {{PTR_W{1'b0}}, inflight_q};
  assign w_fetch_en  = (bus.prog_len > pc_q) && (w_occupancy < c_DEPTH);

  assign w_push = inflight_q;
  assign w_pop  = (bus.add_valid && bus.add_ready) ||
                  (bus.mul_valid && bus.mul_ready) ||
                  w_illegal_head;

  always_comb begin
    pc_d       = pc_q;
    inflight_d = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
    illegal_d  = w_illegal_head;
    if (w_fetch_en) begin
      pc_d       = pc_q + 32'd1;
      inflight_d = 1'b1;
    end
    if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      pc_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      illegal_q  <= illegal_d;
    end
  end

  // Queue storage carries no reset; the pointers and count define validity.
  always_ff @(posedge clk1) begin
    if (rst_n && w_push) mem_q[wr_ptr_q] <= bus.instr_in[15:0];
  end

  assign bus.pc        = pc_q;
  assign bus.iss_op    = w_head[15:12];
  assign bus.iss_rd    = w_head[11:8];
  assign bus.iss_rs1   = w_head[7:4];
  assign bus.iss_rs2   = w_head[3:0];
  assign bus.add_valid = !w_empty && w_add_cls;
  assign bus.mul_valid = !w_empty && w_mul_cls;
  assign bus.illegal   = illegal_q;
  assign bus.done      = (pc_q == bus.prog_len) && w_empty && !inflight_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_issue_queue.sv
`default_nettype none
// =============================================================================
// Module : tb_fetch_issue_queue
// Desc   : Directed bench: per-cycle vector table plus multi-cycle sequences.
// Rev    : 1.0  initial release
// =============================================================================
module tb_fetch_issue_queue;
  logic clk1;
  logic rst_n;

  fetch_issue_queue_if bus ();

  fetch_issue_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          prog;
    logic        rst_n;
    logic [31:0] plen;
    logic        ardy;
    logic        mrdy;
    logic        chk;
    logic [31:0] pc;
    logic [3:0]  flags;  // {add_valid, mul_valid, illegal, done}
    logic        ci;
    logic [15:0] iss;
  } vec_t;

  vec_t        tbl [$];
  logic [15:0] imem [16];
  logic [15:0] expw [$];
  int          n_cmp;
  int          n_bad;
  int          first;
  int          hs;

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Instruction memory: address sampled at the edge, data valid the next cycle.
  always @(posedge clk1) begin
    if (bus.pc < 32'd16) bus.instr_in <= {16'hABCD, imem[bus.pc[3:0]]};
    else                 bus.instr_in <= 32'hABCD_F000;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_prog(input int p);
    for (int i = 0; i < 16; i++) imem[i] = 16'h0000;
    case (p)
      1: begin
        imem[0] = 16'h2123; imem[1] = 16'h0456; imem[2] = 16'h0789;
        imem[3] = 16'h0DEF; imem[4] = 16'h2321; imem[5] = 16'h3654;
      end
      2: begin
        for (int i = 0; i < 8; i++) begin
          logic [3:0] ii;
          ii = 4'(i);
          imem[i] = {2'b00, ii[1:0], ii, ii + 4'd1, 4'd15 - ii};
        end
      end
      3: begin
        imem[0] = 16'h2111; imem[1] = 16'h0222;
      end
      4: begin
        imem[0] = 16'h0111; imem[1] = 16'hF123; imem[2] = 16'h2333;
      end
      default: ;
    endcase
  endtask

  function automatic vec_t mk(input int prog, input logic r, input logic [31:0] pl,
                              input logic ar, input logic mr, input logic c,
                              input logic [31:0] pc, input logic [3:0] fl,
                              input logic ci, input logic [15:0] iss);
    vec_t v;
    v.prog = prog; v.rst_n = r; v.plen = pl; v.ardy = ar; v.mrdy = mr;
    v.chk = c; v.pc = pc; v.flags = fl; v.ci = ci; v.iss = iss;
    return v;
  endfunction

  function automatic logic [3:0] flags_now();
    return {bus.add_valid, bus.mul_valid, bus.illegal, bus.done};
  endfunction

  task automatic do_reset();
    @(negedge clk1);
    rst_n = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  // Samples the current cycle first, then one cycle per iteration.
  task automatic collect(input string tag, input int budget, output int first_cyc);
    int got;
    got = 0;
    first_cyc = -1;
    for (int cyc = 0; cyc < budget && got < expw.size(); cyc++) begin
      if (cyc > 0) @(negedge clk1);
      #1;
      if ((bus.add_valid && bus.add_ready) || (bus.mul_valid && bus.mul_ready)) begin
        if (first_cyc < 0) first_cyc = cyc;
        chk($sformatf("%s.word%0d", tag, got),
            {16'h0, bus.iss_op, bus.iss_rd, bus.iss_rs1, bus.iss_rs2}, {16'h0, expw[got]});
        got++;
      end
    end
    chk($sformatf("%s.issued", tag), 32'(got), 32'(expw.size()));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.prog_len  = 32'd0;
    bus.add_ready = 1'b0;
    bus.mul_ready = 1'b0;
    load_prog(0);

    // Matmul stream: reset state, 2-cycle latency, one issue per cycle, done.
    tbl.push_back(mk(1, 0, 6, 1, 1, 0, 0, 4'b0000, 0, 16'h0));
    tbl.push_back(mk(1, 0, 6, 1, 1, 0, 0, 4'b0000, 0, 16'h0));
    tbl.push_back(mk(1, 1, 6, 1, 1, 1, 0, 4'b0000, 0, 16'h0));
    tbl.push_back(mk(1, 1, 6, 1, 1, 1, 1, 4'b0000, 0, 16'h0));
    tbl.push_back(mk(1, 1, 6, 1, 1, 1, 2, 4'b0100, 1, 16'h2123));
    tbl.push_back(mk(1, 1, 6, 1, 1, 1, 3, 4'b1000, 1, 16'h0456));
    tbl.push_back(mk(1, 1, 6, 1, 1, 1, 4, 4'b1000, 1, 16'h0789));
    tbl.push_back(mk(1, 1, 6, 1, 1, 1, 5, 4'b1000, 1, 16'h0DEF));
    tbl.push_back(mk(1, 1, 6, 1, 1, 1, 6, 4'b0100, 1, 16'h2321));
    tbl.push_back(mk(1, 1, 6, 1, 1, 1, 6, 4'b0100, 1, 16'h3654));
    tbl.push_back(mk(1, 1, 6, 1, 1, 1, 6, 4'b0001, 0, 16'h0));
    tbl.push_back(mk(1, 1, 6, 1, 1, 1, 6, 4'b0001, 0, 16'h0));
    // Illegal word at pc=1: discarded silently, pulse one cycle later.
    tbl.push_back(mk(4, 0, 3, 1, 1, 0, 0, 4'b0000, 0, 16'h0));
    tbl.push_back(mk(4, 0, 3, 1, 1, 0, 0, 4'b0000, 0, 16'h0));
    tbl.push_back(mk(4, 1, 3, 1, 1, 1, 0, 4'b0000, 0, 16'h0));
    tbl.push_back(mk(4, 1, 3, 1, 1, 1, 1, 4'b0000, 0, 16'h0));
    tbl.push_back(mk(4, 1, 3, 1, 1, 1, 2, 4'b1000, 1, 16'h0111));
    tbl.push_back(mk(4, 1, 3, 1, 1, 1, 3, 4'b0000, 1, 16'hF123));
    tbl.push_back(mk(4, 1, 3, 1, 1, 1, 3, 4'b0110, 1, 16'h2333));
    tbl.push_back(mk(4, 1, 3, 1, 1, 1, 3, 4'b0001, 0, 16'h0));
    // Empty program: done from the first cycle, never a valid.
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 4'b0000, 0, 16'h0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 4'b0000, 0, 16'h0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 0, 1, 1, 1, 0, 4'b0001, 0, 16'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk1);
      load_prog(tbl[i].prog);
      rst_n         = tbl[i].rst_n;
      bus.prog_len  = tbl[i].plen;
      bus.add_ready = tbl[i].ardy;
      bus.mul_ready = tbl[i].mrdy;
      #1;
      if (tbl[i].chk) begin
        chk($sformatf("row%0d.pc", i), bus.pc, tbl[i].pc);
        chk($sformatf("row%0d.flags", i), {28'h0, flags_now()}, {28'h0, tbl[i].flags});
        if (tbl[i].ci)
          chk($sformatf("row%0d.iss", i),
              {16'h0, bus.iss_op, bus.iss_rd, bus.iss_rs1, bus.iss_rs2}, {16'h0, tbl[i].iss});
      end
    end

    // Back-pressure: queue fills, pc stops at 4, then all 8 words drain in order.
    load_prog(2);
    expw.delete();
    for (int i = 0; i < 8; i++) expw.push_back(imem[i]);
    bus.prog_len = 32'd8; bus.add_ready = 1'b0; bus.mul_ready = 1'b0;
    do_reset();
    repeat (10) @(negedge clk1);
    #1;
    chk("fill.pc", bus.pc, 32'd4);
    chk("fill.flags", {28'h0, flags_now()}, {28'h0, 4'b1000});
    chk("fill.head", {16'h0, bus.iss_op, bus.iss_rd, bus.iss_rs1, bus.iss_rs2}, {16'h0, expw[0]});
    bus.add_ready = 1'b1; bus.mul_ready = 1'b1;
    collect("drain", 40, first);
    repeat (2) @(negedge clk1);
    #1;
    chk("drain.end", {28'h0, flags_now()}, {28'h0, 4'b0001});

    // Stalled MUL head blocks the ADD behind it.
    load_prog(3);
    bus.prog_len = 32'd2; bus.add_ready = 1'b1; bus.mul_ready = 1'b0;
    do_reset();
    hs = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk1);
      #1;
      if ((bus.add_valid && bus.add_ready) || (bus.mul_valid && bus.mul_ready)) hs++;
    end
    chk("stall.issues", 32'(hs), 32'd0);
    chk("stall.flags", {28'h0, flags_now()}, {28'h0, 4'b0100});
    chk("stall.head", {16'h0, bus.iss_op, bus.iss_rd, bus.iss_rs1, bus.iss_rs2}, 32'h2111);
    expw.delete();
    expw.push_back(16'h2111);
    expw.push_back(16'h0222);
    bus.mul_ready = 1'b1;
    collect("unstall", 10, first);
    chk("unstall.first", 32'(first), 32'd0);

    // Reset with 3 queued + 1 in flight discards everything; refetch from word 0.
    load_prog(2);
    expw.delete();
    for (int i = 0; i < 8; i++) expw.push_back(imem[i]);
    bus.prog_len = 32'd8; bus.add_ready = 1'b0; bus.mul_ready = 1'b0;
    do_reset();
    repeat (4) @(negedge clk1);
    #1;
    chk("midrst.pc_before", bus.pc, 32'd4);
    rst_n = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;
    #1;
    chk("midrst.pc", bus.pc, 32'd0);
    chk("midrst.flags", {28'h0, flags_now()}, {28'h0, 4'b0000});
    bus.add_ready = 1'b1; bus.mul_ready = 1'b1;
    collect("refetch", 40, first);
    chk("refetch.latency", 32'(first), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
